// File: rtl/fp_convert_pipe.sv
// fp_convert_pipe: two-stage valid/ready pipeline around a combinational
// fp32 <-> int32 converter, sitting between FP issue and writeback.
//
// Stage p1 captures command, resolved rounding mode and operands at accept.
// Stage p2 holds the converter result, fflags and the illegal-rm indication
// until writeback takes it.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   flush             kill every in-flight op at the next edge
//   in_valid/in_ready request handshake (in_ready does not look at in_valid)
//   in_command        conversion selector (fp_converter_command_t)
//   in_rm, frm        instruction rm field (3'b111 = dynamic) and fcsr.frm
//   in_int_src        32-bit integer operand
//   in_fp_src         FP operand, fp32 in the low 32 bits
//   out_valid/ready   result handshake
//   out_int_result    integer result (fp->int commands)
//   out_fp_result     FP result, fp32 in the low 32 bits (int->fp commands)
//   out_flags         per-op fflags {NV,DZ,OF,UF,NX}
//   out_illegal       resolved rm is reserved; the op must trap
//   fflags_acc        sticky accumulated fflags
//   fflags_clear      clear the accumulator (CSR write of fflags)
//
// Build option: define FP_CVT_FLAG_ACCUM_EN to build the sticky fflags
// accumulator; otherwise fflags_acc is tied to zero and fflags_clear ignored.

package fp_convert_pkg;
  typedef enum logic [2:0] {
    CVT_W_S  = 3'd0,  // fp32 -> signed int32
    CVT_WU_S = 3'd1,  // fp32 -> unsigned int32
    CVT_S_W  = 3'd2,  // signed int32 -> fp32
    CVT_S_WU = 3'd3   // unsigned int32 -> fp32
  } fp_converter_command_t;
endpackage

module fp_convert_pipe
  import fp_convert_pkg::*;
#(
  parameter int FLAGS_W = 5,
  parameter int FP_W    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  fp_converter_command_t in_command,
  input  logic [2:0]            in_rm,
  input  logic signed [31:0]    in_int_src,
  input  logic [FP_W-1:0]       in_fp_src,
  input  logic [2:0]            frm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_int_result,
  output logic [FP_W-1:0]       out_fp_result,
  output logic [FLAGS_W-1:0]    out_flags,
  output logic                  out_illegal,
  output logic [FLAGS_W-1:0]    fflags_acc,
  input  logic                  fflags_clear
);

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;
  localparam int NV_BIT = 4;
  localparam int NX_BIT = 0;

  // Round-up decision from the kept lsb, round bit and sticky bit.
  function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                     input logic lsb, input logic rb, input logic sb);
    case (rm)
      RM_RNE:  return rb && (sb || lsb);
      RM_RTZ:  return 1'b0;
      RM_RDN:  return sign && (rb || sb);
      RM_RUP:  return !sign && (rb || sb);
      RM_RMM:  return rb;
      default: return 1'b0;
    endcase
  endfunction

  // Out-of-range fp->int saturation value.
  function automatic logic [31:0] int_saturate(input logic sign, input logic uns);
    if (uns) return sign ? 32'h0000_0000 : 32'hFFFF_FFFF;
    return sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endfunction

  // fp32 -> int32. Returns {NV, NX, result}. NaN gives 0 with NV.
  function automatic logic [33:0] fp32_to_int(input logic [31:0] f, input logic uns,
                                               input logic [2:0] rm);
    logic        sign;
    logic [7:0]  ex;
    logic [63:0] fx;
    logic [32:0] mag;
    logic        rb, sb, inc, nv, nx;
    logic [31:0] res;
    sign = f[31];
    ex   = f[30:23];
    fx   = '0;
    mag  = '0;
    rb   = 1'b0;
    sb   = 1'b0;
    inc  = 1'b0;
    nv   = 1'b0;
    nx   = 1'b0;
    res  = '0;
    if (ex == 8'hFF && f[22:0] != '0) begin
      nv = 1'b1;
    end else if (ex >= 8'd159) begin
      // |x| >= 2^32 (or infinity): out of range for every destination
      nv  = 1'b1;
      res = int_saturate(sign, uns);
    end else begin
      // fx is |x| in Q32.32; anything below 2^-9 only contributes sticky
      if (ex >= 8'd118) fx = {40'd0, 1'b1, f[22:0]} << (ex - 8'd118);
      else              sb = (f[30:0] != '0);
      rb  = fx[31];
      sb  = sb | (|fx[30:0]);
      inc = round_inc(rm, sign, fx[32], rb, sb);
      mag = {1'b0, fx[63:32]} + {32'd0, inc};
      if (uns) begin
        if (sign && mag != '0) begin
          nv  = 1'b1;
        end else if (mag[32]) begin
          nv  = 1'b1;
          res = 32'hFFFF_FFFF;
        end else begin
          res = mag[31:0];
          nx  = rb | sb;
        end
      end else begin
        if (!sign && mag > 33'h0_7FFF_FFFF) begin
          nv  = 1'b1;
          res = 32'h7FFF_FFFF;
        end else if (sign && mag > 33'h0_8000_0000) begin
          nv  = 1'b1;
          res = 32'h8000_0000;
        end else begin
          res = sign ? -mag[31:0] : mag[31:0];
          nx  = rb | sb;
        end
      end
    end
    return {nv, nx, res};
  endfunction

  // int32 -> fp32. Returns {NX, result}; never overflows.
  function automatic logic [32:0] int_to_fp32(input logic signed [31:0] v, input logic uns,
                                              input logic [2:0] rm);
    logic        sign;
    logic [31:0] mag;
    logic [4:0]  p;
    logic [30:0] norm;
    logic        rb, sb, inc;
    logic [30:0] exp_man;
    sign = !uns && (v < 0);
    mag  = sign ? -v : v;
    p    = '0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) p = 5'(i);
    end
    // Leading one shifted to bit 31 and dropped (hidden bit)
    norm    = 31'(mag << (5'd31 - p));
    rb      = norm[7];
    sb      = |norm[6:0];
    inc     = round_inc(rm, sign, norm[8], rb, sb);
    // A mantissa carry ripples into the exponent field
    exp_man = {8'd127 + {3'd0, p}, norm[30:8]} + {30'd0, inc};
    if (mag == '0) return 33'd0;
    else           return {rb | sb, sign, exp_man};
  endfunction

  fp_converter_command_t cmd_p1;
  logic [2:0]            rm_p1;
  logic signed [31:0]    int_src_p1;
  logic [FP_W-1:0]       fp_src_p1;
  logic                  vld_p1;
  logic                  vld_p2;
  logic                  s2_adv;
  logic                  accept;
  logic                  illegal_p1;
  logic [33:0]           f2i;
  logic [32:0]           i2f;
  logic [31:0]           cv_int;
  logic [FP_W-1:0]       cv_fp;
  logic [FLAGS_W-1:0]    cv_flags;

  assign s2_adv     = vld_p1 && (!vld_p2 || out_ready);
  assign in_ready   = !vld_p1 || s2_adv;
  assign accept     = in_valid && in_ready;
  assign out_valid  = vld_p2;
  assign illegal_p1 = (rm_p1 >= 3'b101);

  // ---- stage p1: operands and rounding mode resolved at accept ----
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_p1     <= in_command;
      rm_p1      <= (in_rm == RM_DYN) ? frm : in_rm;
      int_src_p1 <= in_int_src;
      fp_src_p1  <= in_fp_src;
    end
  end

  always_comb begin
    f2i      = '0;
    i2f      = '0;
    cv_int   = '0;
    cv_fp    = '0;
    cv_flags = '0;
    case (cmd_p1)
      CVT_W_S, CVT_WU_S: begin
        f2i              = fp32_to_int(fp_src_p1[31:0], cmd_p1 == CVT_WU_S, rm_p1);
        cv_int           = f2i[31:0];
        cv_flags[NV_BIT] = f2i[33];
        cv_flags[NX_BIT] = f2i[32];
      end
      CVT_S_W, CVT_S_WU: begin
        i2f              = int_to_fp32(int_src_p1, cmd_p1 == CVT_S_WU, rm_p1);
        cv_fp[31:0]      = i2f[31:0];
        cv_flags[NX_BIT] = i2f[32];
      end
      default: ;
    endcase
  end

  generate
    if (FP_W > 32) begin : g_fp_hi
      logic unused_fp_hi;
      assign unused_fp_hi = |fp_src_p1[FP_W-1:32];
    end
  endgenerate

  // ---- stage p2: registered result toward commit ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1         <= 1'b0;
      vld_p2         <= 1'b0;
      out_int_result <= '0;
      out_fp_result  <= '0;
      out_flags      <= '0;
      out_illegal    <= 1'b0;
    end else begin
      if (flush) begin
        vld_p1 <= 1'b0;
        vld_p2 <= 1'b0;
      end else begin
        if (accept)      vld_p1 <= 1'b1;
        else if (s2_adv) vld_p1 <= 1'b0;
        if (s2_adv)         vld_p2 <= 1'b1;
        else if (out_ready) vld_p2 <= 1'b0;
      end
      if (s2_adv) begin
        if (illegal_p1) begin
          out_int_result <= '0;
          out_fp_result  <= '0;
          out_flags      <= '0;
          out_illegal    <= 1'b1;
        end else begin
          out_int_result <= cv_int;
          out_fp_result  <= cv_fp;
          out_flags      <= cv_flags;
          out_illegal    <= 1'b0;
        end
      end
    end
  end

`ifdef FP_CVT_FLAG_ACCUM_EN
  // A flushed result is not consumed, so it never reaches the accumulator.
  logic acc_hs;
  assign acc_hs = vld_p2 && out_ready && !flush && !out_illegal;

  always_ff @(posedge clk) begin
    if (!rst)              fflags_acc <= '0;
    else if (fflags_clear) fflags_acc <= acc_hs ? out_flags : '0;
    else if (acc_hs)       fflags_acc <= fflags_acc | out_flags;
  end
`else
  logic unused_clear;
  assign unused_clear = fflags_clear;
  assign fflags_acc   = '0;
`endif

endmodule

// File: tb/tb_fp_convert_pipe.sv
// Scoreboard bench for fp_convert_pipe: directed conversions with
// hand-computed results, backpressure, flush and (when built with
// FP_CVT_FLAG_ACCUM_EN) the sticky fflags accumulator.
module tb_fp_convert_pipe;
  import fp_convert_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  fp_converter_command_t in_command;
  logic [2:0]            in_rm;
  logic signed [31:0]    in_int_src;
  logic [63:0]           in_fp_src;
  logic [2:0]            frm;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_int_result;
  logic [63:0]           out_fp_result;
  logic [4:0]            out_flags;
  logic                  out_illegal;
  logic [4:0]            fflags_acc;
  logic                  fflags_clear;

  always #5 clk = ~clk;

  fp_convert_pipe #(.FLAGS_W(5), .FP_W(64)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_command(in_command),
    .in_rm(in_rm), .in_int_src(in_int_src), .in_fp_src(in_fp_src), .frm(frm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_int_result(out_int_result), .out_fp_result(out_fp_result),
    .out_flags(out_flags), .out_illegal(out_illegal),
    .fflags_acc(fflags_acc), .fflags_clear(fflags_clear)
  );

  typedef struct {
    logic [31:0] i;
    logic [63:0] f;
    logic [4:0]  fl;
    logic        ill;
    int          id;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   op_id  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every consumed result is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready && !flush) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: int=0x%0h fp=0x%0h with nothing outstanding",
                 out_int_result, out_fp_result);
      end else begin
        mon_e = q.pop_front();
        if (out_int_result !== mon_e.i || out_fp_result !== mon_e.f ||
            out_flags !== mon_e.fl || out_illegal !== mon_e.ill) begin
          errors++;
          $display("FAIL op%0d: actual int=0x%0h fp=0x%0h flags=%b ill=%b required int=0x%0h fp=0x%0h flags=%b ill=%b",
                   mon_e.id, out_int_result, out_fp_result, out_flags, out_illegal,
                   mon_e.i, mon_e.f, mon_e.fl, mon_e.ill);
        end
      end
    end
  end

  // Present one request and hold it until accepted; record its expected result.
  task automatic send(input fp_converter_command_t cmd, input logic [2:0] rm,
                      input logic [31:0] isrc, input logic [31:0] fsrc, input logic [2:0] frm_v,
                      input bit exp_out, input logic [31:0] ei, input logic [31:0] ef,
                      input logic [4:0] efl, input logic eill);
    in_valid   = 1'b1;
    in_command = cmd;
    in_rm      = rm;
    in_int_src = isrc;
    in_fp_src  = {32'h0, fsrc};
    frm        = frm_v;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (in_ready) begin
        if (exp_out) q.push_back('{ei, {32'h0, ef}, efl, eill, op_id});
        op_id++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: in_ready=0 for 64 cycles, required 1");
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: outstanding=%0d required=0", tag, q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_command = CVT_W_S; in_rm = 3'b000;
    in_int_src = '0; in_fp_src = '0; frm = 3'b000; out_ready = 1'b1; fflags_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_int", out_int_result, 0);
    chk("rst_out_fp", out_fp_result, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_fflags_acc", fflags_acc, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    // Latency: 1.0 -> 1, visible two edges after accept
    send(CVT_W_S, 3'b000, 0, 32'h3F80_0000, 3'b000, 1, 32'd1, 0, 5'b00000, 0);
    @(negedge clk);
    chk("latency_edge1_out_valid", out_valid, 0);
    @(negedge clk);
    chk("latency_edge2_out_valid", out_valid, 1);
    @(posedge clk);
    #1;

    // Directed conversions, back-to-back
    send(CVT_W_S,  3'b111, 0, 32'h7FC0_0000, 3'b001, 1, 32'h0,         0, 5'b10000, 0); // NaN
    send(CVT_W_S,  3'b111, 0, 32'h3FC0_0000, 3'b001, 1, 32'd1,         0, 5'b00001, 0); // 1.5 dyn RTZ
    send(CVT_W_S,  3'b111, 0, 32'h3FC0_0000, 3'b000, 1, 32'd2,         0, 5'b00001, 0); // frm now RNE
    send(CVT_W_S,  3'b000, 0, 32'h4020_0000, 3'b000, 1, 32'd2,         0, 5'b00001, 0); // 2.5 ties even
    send(CVT_W_S,  3'b010, 0, 32'hBFC0_0000, 3'b000, 1, 32'hFFFF_FFFE, 0, 5'b00001, 0); // -1.5 RDN
    send(CVT_W_S,  3'b001, 0, 32'h4F80_0000, 3'b000, 1, 32'h7FFF_FFFF, 0, 5'b10000, 0); // 2^32
    send(CVT_W_S,  3'b000, 0, 32'hCF00_0000, 3'b000, 1, 32'h8000_0000, 0, 5'b00000, 0); // -2^31
    send(CVT_WU_S, 3'b000, 0, 32'hBF80_0000, 3'b000, 1, 32'h0,         0, 5'b10000, 0); // -1.0
    send(CVT_WU_S, 3'b000, 0, 32'h4F00_0000, 3'b000, 1, 32'h8000_0000, 0, 5'b00000, 0); // 2^31
    send(CVT_WU_S, 3'b000, 0, 32'hBE80_0000, 3'b000, 1, 32'h0,         0, 5'b00001, 0); // -0.25
    send(CVT_S_W,  3'b000, 32'd1,         0, 3'b000, 1, 0, 32'h3F80_0000, 5'b00000, 0);
    send(CVT_S_W,  3'b000, 32'hFFFF_FFFF, 0, 3'b000, 1, 0, 32'hBF80_0000, 5'b00000, 0);
    send(CVT_S_W,  3'b000, 32'h7FFF_FFFF, 0, 3'b000, 1, 0, 32'h4F00_0000, 5'b00001, 0);
    send(CVT_S_W,  3'b000, 32'h0100_0001, 0, 3'b000, 1, 0, 32'h4B80_0000, 5'b00001, 0);
    send(CVT_S_W,  3'b011, 32'h0100_0001, 0, 3'b000, 1, 0, 32'h4B80_0001, 5'b00001, 0);
    send(CVT_S_WU, 3'b001, 32'hFFFF_FFFF, 0, 3'b000, 1, 0, 32'h4F7F_FFFF, 5'b00001, 0);
    send(CVT_W_S,  3'b101, 0, 32'h3F80_0000, 3'b000, 1, 0, 0, 5'b00000, 1);             // reserved rm
    send(CVT_W_S,  3'b111, 0, 32'h3F80_0000, 3'b110, 1, 0, 0, 5'b00000, 1);             // reserved frm
    send(fp_converter_command_t'(3'd6), 3'b000, 32'd5, 32'h3F80_0000, 3'b000, 1, 0, 0, 5'b00000, 0);
    drain("directed");
`ifndef FP_CVT_FLAG_ACCUM_EN
    chk("acc_tied_zero", fflags_acc, 0);
`endif

    // Backpressure: four ops while writeback stalls
    out_ready = 1'b0;
    fork
      begin
        send(CVT_W_S, 3'b000, 0, 32'h3F80_0000, 3'b000, 1, 32'd1, 0, 5'b00000, 0);
        send(CVT_W_S, 3'b000, 0, 32'h4000_0000, 3'b000, 1, 32'd2, 0, 5'b00000, 0);
        send(CVT_W_S, 3'b000, 0, 32'h4040_0000, 3'b000, 1, 32'd3, 0, 5'b00000, 0);
        send(CVT_W_S, 3'b000, 0, 32'h4080_0000, 3'b000, 1, 32'd4, 0, 5'b00000, 0);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_hold_data_a", out_int_result, 1);
        @(negedge clk);
        chk("bp_in_ready_still_low", in_ready, 0);
        chk("bp_hold_data_b", out_int_result, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("backpressure");

    // Flush with both stages full and a concurrent request
    out_ready = 1'b0;
    send(CVT_W_S, 3'b000, 0, 32'h3F80_0000, 3'b000, 0, 0, 0, 0, 0);
    send(CVT_W_S, 3'b000, 0, 32'h4000_0000, 3'b000, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush_pre_out_valid", out_valid, 1);
    chk("flush_pre_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    in_command = CVT_W_S; in_rm = 3'b000; in_fp_src = 64'h4080_0000;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("flush_out_valid_%0d", k), out_valid, 0);
      chk($sformatf("flush_in_ready_%0d", k), in_ready, 1);
    end
    @(posedge clk);
    #1;
    send(CVT_W_S, 3'b000, 0, 32'h4040_0000, 3'b000, 1, 32'd3, 0, 5'b00000, 0);
    drain("post_flush");

`ifdef FP_CVT_FLAG_ACCUM_EN
    fflags_clear = 1'b1;
    @(posedge clk);
    #1 fflags_clear = 1'b0;
    @(negedge clk);
    chk("acc_cleared", fflags_acc, 5'b00000);
    @(posedge clk);
    #1;
    send(CVT_W_S, 3'b000, 0, 32'h3FC0_0000, 3'b000, 1, 32'd2, 0, 5'b00001, 0);
    send(CVT_W_S, 3'b000, 0, 32'h7FC0_0000, 3'b000, 1, 32'd0, 0, 5'b10000, 0);
    drain("acc_ops");
    chk("acc_nx_nv", fflags_acc, 5'b10001);
    send(CVT_W_S, 3'b101, 0, 32'h7FC0_0000, 3'b000, 1, 0, 0, 5'b00000, 1);
    drain("acc_illegal");
    chk("acc_illegal_unchanged", fflags_acc, 5'b10001);
    out_ready = 1'b0;
    send(CVT_W_S, 3'b000, 0, 32'h3FC0_0000, 3'b000, 1, 32'd2, 0, 5'b00001, 0);
    @(posedge clk);
    #1;
    fflags_clear = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 fflags_clear = 1'b0;
    @(negedge clk);
    chk("acc_clear_with_handshake", fflags_acc, 5'b00001);
    drain("acc_clear");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
